// File: rtl/weight_stream_mem.sv
// rtl/weight_stream_mem.sv - runtime-loadable per-neuron weight buffer
// Valid/ready load stream in, valid/ready/last weight stream out, plus a registered debug read port.
module weight_stream_mem #(
  parameter int NUM_WEIGHT = 10,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  wvalid,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wready,
  output logic                  loaded,
  input  logic                  stream_start,
  output logic                  ovalid,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  olast,
  input  logic                  oready,
  output logic                  busy,
  output logic                  err,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] radd,
  output logic [DATA_WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WEIGHT - 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [NUM_WEIGHT];
  logic [ADDR_WIDTH-1:0] waddr, rptr;
  logic                  wr_fire, out_adv, out_done;
  logic                  go_load, go_stream, bad_stream;
  logic                  radd_ok;

  assign wready     = (state == LOAD);
  assign busy       = (state != IDLE);
  assign wr_fire    = wready & wvalid;
  assign go_load    = (state == IDLE) & load_start;
  assign go_stream  = (state == IDLE) & ~load_start & stream_start & loaded;
  assign bad_stream = (state == IDLE) & ~load_start & stream_start & ~loaded;
  // Once the last word sits in the output register, only its handshake may move the stream on.
  assign out_done   = (state == STREAM) & ovalid & olast & oready;
  assign out_adv    = (state == STREAM) & ~(ovalid & olast) & (~ovalid | oready);
  assign radd_ok    = (32'(radd) < NUM_WEIGHT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go_load)        state_nxt = LOAD;
        else if (go_stream) state_nxt = STREAM;
      end
      LOAD:    if (wr_fire && waddr == LAST) state_nxt = IDLE;
      STREAM:  if (out_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weight storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr  <= '0;
      rptr   <= '0;
      loaded <= 1'b0;
      ovalid <= 1'b0;
      odata  <= '0;
      olast  <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      err <= bad_stream;

      if (go_load) begin
        waddr  <= '0;
        loaded <= 1'b0;
      end else if (wr_fire) begin
        if (waddr == LAST) loaded <= 1'b1;
        else               waddr  <= waddr + 1'b1;
      end

      if (go_stream) begin
        rptr <= '0;
      end else if (out_done) begin
        ovalid <= 1'b0;
        olast  <= 1'b0;
      end else if (out_adv) begin
        odata  <= mem[rptr];
        ovalid <= 1'b1;
        olast  <= (rptr == LAST);
        if (rptr != LAST) rptr <= rptr + 1'b1;
      end

      if (ren) rdata <= radd_ok ? mem[radd] : '0;
    end
  end

endmodule

// File: tb/tb_weight_stream_mem.sv
// tb/tb_weight_stream_mem.sv - directed self-checking bench for weight_stream_mem
module tb_weight_stream_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, wvalid, wready, loaded;
  logic [15:0] wdata;
  logic        stream_start, ovalid, olast, oready, busy, err, ren;
  logic [15:0] odata, rdata;
  logic [3:0]  radd;

  int errors = 0;
  int checks = 0;
  int idx;
  int cyc;

  weight_stream_mem #(.NUM_WEIGHT(10), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .wvalid(wvalid), .wdata(wdata), .wready(wready), .loaded(loaded),
    .stream_start(stream_start), .ovalid(ovalid), .odata(odata), .olast(olast), .oready(oready),
    .busy(busy), .err(err), .ren(ren), .radd(radd), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; wvalid = 1'b0; wdata = '0;
    stream_start = 1'b0; oready = 1'b0; ren = 1'b0; radd = '0;
    tick(); tick();
    chk("rst_ovalid", ovalid, 0);
    chk("rst_odata", odata, 0);
    chk("rst_olast", olast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wready", wready, 0);
    rst_n = 1'b1;
    tick();

    // stream request with nothing loaded
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_ovalid", ovalid, 0);
    tick();
    chk("err_clear", err, 0);
    chk("err_ovalid2", ovalid, 0);

    // load 0x0100..0x0109
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_loaded_clr", loaded, 0);
    for (int i = 0; i < 10; i++) begin
      wvalid = 1'b1;
      wdata  = 16'h0100 + 16'(i);
      chk($sformatf("load_wready_%0d", i), wready, 1);
      tick();
    end
    wvalid = 1'b0;
    chk("load_loaded", loaded, 1);
    chk("load_wready_off", wready, 0);
    chk("load_busy_off", busy, 0);

    // random read port
    ren = 1'b1; radd = 4'd3;
    tick();
    chk("rd_addr3", rdata, 16'h0103);
    radd = 4'd12;
    tick();
    chk("rd_addr12", rdata, 16'h0000);
    radd = 4'd9;
    tick();
    chk("rd_addr9", rdata, 16'h0109);
    ren = 1'b0; radd = 4'd5;
    tick();
    chk("rd_hold", rdata, 16'h0109);

    // full-rate stream
    stream_start = 1'b1; oready = 1'b1;
    tick();
    stream_start = 1'b0;
    chk("str_busy", busy, 1);
    chk("str_first_lat", ovalid, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("str_ovalid_%0d", i), ovalid, 1);
      chk($sformatf("str_odata_%0d", i), odata, 16'h0100 + 16'(i));
      chk($sformatf("str_olast_%0d", i), olast, (i == 9) ? 1 : 0);
    end
    tick();
    chk("str_end_ovalid", ovalid, 0);
    chk("str_end_busy", busy, 0);
    chk("str_end_loaded", loaded, 1);

    // stalled stream, oready pattern 1,0,0 repeating
    stream_start = 1'b1; oready = 1'b0;
    tick();
    stream_start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 100) begin
      oready = (cyc % 3 == 0);
      if (ovalid) begin
        chk($sformatf("stall_odata_c%0d", cyc), odata, 16'h0100 + 16'(idx));
        chk($sformatf("stall_olast_c%0d", cyc), olast, (idx == 9) ? 1 : 0);
        if (oready) idx++;
      end
      tick();
      cyc++;
    end
    chk("stall_count", idx, 10);
    oready = 1'b0;
    chk("stall_end_ovalid", ovalid, 0);
    chk("stall_end_busy", busy, 0);

    // reset in the middle of a stream
    stream_start = 1'b1; oready = 1'b1;
    tick();
    stream_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_word5", odata, 16'h0104);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", ovalid, 0);
    chk("mid_rst_loaded", loaded, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    chk("mid_err", err, 1);
    chk("mid_ovalid", ovalid, 0);

    // same-address read and write returns the old word; load_start beats stream_start
    load_start = 1'b1; stream_start = 1'b1;
    tick();
    load_start = 1'b0; stream_start = 1'b0;
    chk("prio_wready", wready, 1);
    chk("prio_err", err, 0);
    wvalid = 1'b1; wdata = 16'hBEEF; ren = 1'b1; radd = 4'd0;
    tick();
    wvalid = 1'b0;
    chk("rbw_old", rdata, 16'h0100);
    tick();
    chk("rbw_new", rdata, 16'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
